// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: latches the decoded control word and ID operands into EX,
// detects load-use hazards, applies flush/hold, and counts inserted bubbles.
module id_ex_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold_i,
   input  logic              flush_i,
   input  logic              id_valid,
   input  logic [1:0]        id_RegDst,
   input  logic              id_ALUSrc,
   input  logic              id_MemtoReg,
   input  logic              id_RegWrite,
   input  logic              id_MemRead,
   input  logic              id_MemWrite,
   input  logic              id_Jump,
   input  logic              id_BranchBEQ,
   input  logic              id_BranchBNE,
   input  logic [1:0]        id_RegWriteSrc,
   input  logic [2:0]        id_ALUOp,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [REG_AW-1:0] id_shamt,
   input  logic [5:0]        id_funct,
   output logic              ex_valid,
   output logic [1:0]        ex_RegDst,
   output logic              ex_ALUSrc,
   output logic              ex_MemtoReg,
   output logic              ex_RegWrite,
   output logic              ex_MemRead,
   output logic              ex_MemWrite,
   output logic              ex_Jump,
   output logic              ex_BranchBEQ,
   output logic              ex_BranchBNE,
   output logic [1:0]        ex_RegWriteSrc,
   output logic [2:0]        ex_ALUOp,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic [REG_AW-1:0] ex_shamt,
   output logic [5:0]        ex_funct,
   output logic              stall_o,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic load_use;
   logic kill_ctrl;
   logic load_data;
   logic cnt_inc;

   // Both source fields are compared whatever the format; a false stall costs one cycle.
   assign load_use = id_valid & ex_valid & ex_MemRead & (ex_rt != '0) &
                     ((ex_rt == id_rs) | (ex_rt == id_rt));

   assign stall_o   = load_use & ~flush_i;
   assign kill_ctrl = flush_i | load_use | ~id_valid;
   assign load_data = ~flush_i & ~load_use;
   assign cnt_inc   = ~flush_i & load_use & ~(&bubble_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid       <= 1'b0;
         ex_RegDst      <= '0;
         ex_ALUSrc      <= 1'b0;
         ex_MemtoReg    <= 1'b0;
         ex_RegWrite    <= 1'b0;
         ex_MemRead     <= 1'b0;
         ex_MemWrite    <= 1'b0;
         ex_Jump        <= 1'b0;
         ex_BranchBEQ   <= 1'b0;
         ex_BranchBNE   <= 1'b0;
         ex_RegWriteSrc <= '0;
         ex_ALUOp       <= '0;
      end else if (!hold_i) begin
         if (kill_ctrl) begin
            ex_valid       <= 1'b0;
            ex_RegDst      <= '0;
            ex_ALUSrc      <= 1'b0;
            ex_MemtoReg    <= 1'b0;
            ex_RegWrite    <= 1'b0;
            ex_MemRead     <= 1'b0;
            ex_MemWrite    <= 1'b0;
            ex_Jump        <= 1'b0;
            ex_BranchBEQ   <= 1'b0;
            ex_BranchBNE   <= 1'b0;
            ex_RegWriteSrc <= '0;
            ex_ALUOp       <= '0;
         end else begin
            ex_valid       <= 1'b1;
            ex_RegDst      <= id_RegDst;
            ex_ALUSrc      <= id_ALUSrc;
            ex_MemtoReg    <= id_MemtoReg;
            ex_RegWrite    <= id_RegWrite;
            ex_MemRead     <= id_MemRead;
            ex_MemWrite    <= id_MemWrite;
            ex_Jump        <= id_Jump;
            ex_BranchBEQ   <= id_BranchBEQ;
            ex_BranchBNE   <= id_BranchBNE;
            ex_RegWriteSrc <= id_RegWriteSrc;
            ex_ALUOp       <= id_ALUOp;
         end
      end
   end

   // Operands keep their last value on flush/bubble; only the control word is zeroed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_pc4     <= '0;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         ex_shamt   <= '0;
         ex_funct   <= '0;
      end else if (!hold_i && load_data) begin
         ex_pc4     <= id_pc4;
         ex_rs_data <= id_rs_data;
         ex_rt_data <= id_rt_data;
         ex_imm     <= id_imm;
         ex_rs      <= id_rs;
         ex_rt      <= id_rt;
         ex_rd      <= id_rd;
         ex_shamt   <= id_shamt;
         ex_funct   <= id_funct;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (!hold_i && cnt_inc) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg against a cycle-level reference model.
module tb_id_ex_pipe_reg;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic hold_i, flush_i, id_valid;
   logic [14:0] id_ctrl;
   logic [DW-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
   logic [AW-1:0] id_rs, id_rt, id_rd, id_shamt;
   logic [5:0] id_funct;

   logic ex_valid, stall_o;
   logic [1:0] ex_RegDst, ex_RegWriteSrc;
   logic ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite;
   logic ex_Jump, ex_BranchBEQ, ex_BranchBNE;
   logic [2:0] ex_ALUOp;
   logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
   logic [AW-1:0] ex_rs, ex_rt, ex_rd, ex_shamt;
   logic [5:0] ex_funct;
   logic [CW-1:0] bubble_cnt;

   // ctrl bit map: RegDst[14:13] ALUSrc12 MemtoReg11 RegWrite10 RegWriteSrc[9:8]
   // MemRead7 MemWrite6 Jump5 BEQ4 BNE3 ALUOp[2:0]
   wire [14:0] ex_ctrl = {ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_RegWriteSrc,
                          ex_MemRead, ex_MemWrite, ex_Jump, ex_BranchBEQ, ex_BranchBNE, ex_ALUOp};
   wire [173:0] dut_word = {ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
                            ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct, bubble_cnt};

   id_ex_pipe_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i), .id_valid(id_valid),
      .id_RegDst(id_ctrl[14:13]), .id_ALUSrc(id_ctrl[12]), .id_MemtoReg(id_ctrl[11]),
      .id_RegWrite(id_ctrl[10]), .id_MemRead(id_ctrl[7]), .id_MemWrite(id_ctrl[6]),
      .id_Jump(id_ctrl[5]), .id_BranchBEQ(id_ctrl[4]), .id_BranchBNE(id_ctrl[3]),
      .id_RegWriteSrc(id_ctrl[9:8]), .id_ALUOp(id_ctrl[2:0]),
      .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct),
      .ex_valid(ex_valid), .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc),
      .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
      .ex_MemWrite(ex_MemWrite), .ex_Jump(ex_Jump), .ex_BranchBEQ(ex_BranchBEQ),
      .ex_BranchBNE(ex_BranchBNE), .ex_RegWriteSrc(ex_RegWriteSrc), .ex_ALUOp(ex_ALUOp),
      .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_funct(ex_funct),
      .stall_o(stall_o), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: what EX should hold after each edge.
   logic m_valid;
   logic [14:0] m_ctrl;
   logic [DW-1:0] m_pc4, m_rsd, m_rtd, m_imm;
   logic [AW-1:0] m_rs, m_rt, m_rd, m_sh;
   logic [5:0] m_fn;
   int m_cnt;

   localparam logic [14:0] CTRL_ADDI = 15'h1400;  // ALUSrc, RegWrite
   localparam logic [14:0] CTRL_LW   = 15'h1C80;  // ALUSrc, MemtoReg, RegWrite, MemRead
   localparam logic [14:0] CTRL_ADD  = 15'h2402;  // RegDst=01, RegWrite, ALUOp=010

   function automatic logic [173:0] exp_word();
      logic [CW-1:0] c;
      c = CW'(m_cnt);
      return {m_valid, m_ctrl, m_pc4, m_rsd, m_rtd, m_imm, m_rs, m_rt, m_rd, m_sh, m_fn, c};
   endfunction

   function automatic logic exp_load_use();
      return id_valid && m_valid && m_ctrl[7] && (m_rt != 0) && (m_rt == id_rs || m_rt == id_rt);
   endfunction

   function automatic logic exp_stall();
      return exp_load_use() && !flush_i;
   endfunction

   task automatic model_clear();
      m_valid = 0; m_ctrl = 0; m_pc4 = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_sh = 0; m_fn = 0; m_cnt = 0;
   endtask

   // Advance the model with the current inputs, then clock the DUT.
   task automatic tick();
      logic lu;
      lu = exp_load_use();
      if (hold_i) begin
      end else if (flush_i) begin
         m_valid = 0; m_ctrl = 0;
      end else if (lu) begin
         m_valid = 0; m_ctrl = 0;
         if (m_cnt < (1 << CW) - 1) m_cnt++;
      end else begin
         m_valid = id_valid;
         m_ctrl  = id_valid ? id_ctrl : 15'h0;
         m_pc4 = id_pc4; m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
         m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_sh = id_shamt; m_fn = id_funct;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [14:0] c, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                            input logic [AW-1:0] rd, input logic [DW-1:0] imm);
      logic [31:0] r;
      r = $urandom;
      id_valid = 1; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; id_imm = imm;
      id_pc4 = {r[29:0], 2'b00}; id_rs_data = $urandom; id_rt_data = $urandom;
      id_shamt = r[4:0]; id_funct = r[10:5];
   endtask

   task automatic test_reset();
      rst_n = 0; hold_i = 0; flush_i = 0;
      set_instr(CTRL_LW, 5'd1, 5'd2, 5'd3, 32'h10);
      model_clear();
      #3;
      checks++;
      if (dut_word !== exp_word() || stall_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got %h stall %b exp %h stall 0", dut_word, stall_o, exp_word());
      end
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_addi();
      set_instr(CTRL_ADDI, 5'd4, 5'd5, 5'd0, 32'h0000_0005);
      tick();
      checks++;
      if (ex_ctrl !== CTRL_ADDI || ex_imm !== 32'h5 || ex_valid !== 1'b1 || dut_word !== exp_word()) begin
         errors++;
         $display("FAIL addi got ctrl %h imm %h valid %b exp ctrl %h imm 5 valid 1",
                  ex_ctrl, ex_imm, ex_valid, CTRL_ADDI);
      end
   endtask

   task automatic test_load_use();
      int c0;
      set_instr(CTRL_LW, 5'd2, 5'd8, 5'd0, 32'h40);
      tick();
      c0 = m_cnt;
      set_instr(CTRL_ADD, 5'd8, 5'd9, 5'd10, 32'h0);
      #1;
      checks++;
      if (stall_o !== 1'b1) begin
         errors++; $display("FAIL lu_stall got %b exp 1", stall_o);
      end
      tick();
      checks++;
      if (ex_valid !== 1'b0 || ex_MemRead !== 1'b0 || int'(bubble_cnt) != c0 + 1 ||
          stall_o !== 1'b0 || dut_word !== exp_word()) begin
         errors++;
         $display("FAIL lu_bubble got valid %b memrd %b cnt %0d stall %b exp 0 0 %0d 0",
                  ex_valid, ex_MemRead, bubble_cnt, stall_o, c0 + 1);
      end
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_ctrl !== CTRL_ADD || ex_rs !== 5'd8 || dut_word !== exp_word()) begin
         errors++;
         $display("FAIL lu_dependent got valid %b ctrl %h rs %0d exp 1 %h 8", ex_valid, ex_ctrl, ex_rs, CTRL_ADD);
      end
   endtask

   task automatic test_rt_zero();
      int c0;
      set_instr(CTRL_LW, 5'd3, 5'd0, 5'd0, 32'h8);
      tick();
      c0 = m_cnt;
      set_instr(CTRL_ADD, 5'd0, 5'd0, 5'd11, 32'h0);
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
         errors++; $display("FAIL rt0_stall got %b exp 0", stall_o);
      end
      tick();
      checks++;
      if (ex_valid !== 1'b1 || int'(bubble_cnt) != c0 || dut_word !== exp_word()) begin
         errors++; $display("FAIL rt0_nobubble got valid %b cnt %0d exp 1 %0d", ex_valid, bubble_cnt, c0);
      end
   endtask

   task automatic test_flush_priority();
      int c0;
      set_instr(CTRL_LW, 5'd1, 5'd8, 5'd0, 32'h4);
      tick();
      c0 = m_cnt;
      set_instr(CTRL_ADD, 5'd8, 5'd8, 5'd12, 32'h0);
      flush_i = 1;
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
         errors++; $display("FAIL flush_stall got %b exp 0", stall_o);
      end
      tick();
      flush_i = 0;
      checks++;
      if (ex_valid !== 1'b0 || int'(bubble_cnt) != c0 || dut_word !== exp_word()) begin
         errors++; $display("FAIL flush_edge got valid %b cnt %0d exp 0 %0d", ex_valid, bubble_cnt, c0);
      end
   endtask

   task automatic test_hold();
      logic [173:0] frozen;
      set_instr(CTRL_LW, 5'd1, 5'd7, 5'd0, 32'h4);
      tick();
      frozen = dut_word;
      set_instr(CTRL_ADD, 5'd7, 5'd2, 5'd13, 32'h0);
      hold_i = 1;
      #1;
      checks++;
      if (stall_o !== 1'b1) begin
         errors++; $display("FAIL hold_stall got %b exp 1", stall_o);
      end
      flush_i = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (dut_word !== frozen || dut_word !== exp_word()) begin
            errors++; $display("FAIL hold_frozen cycle %0d got %h exp %h", i, dut_word, frozen);
         end
      end
      hold_i = 0;
      tick();
      flush_i = 0;
      checks++;
      if (ex_valid !== 1'b0 || bubble_cnt !== frozen[3:0] || dut_word !== exp_word()) begin
         errors++; $display("FAIL hold_release got valid %b cnt %0d exp 0 %0d", ex_valid, bubble_cnt, frozen[3:0]);
      end
   endtask

   task automatic test_reset_mid();
      set_instr(CTRL_LW, 5'd1, 5'd6, 5'd0, 32'h4);
      tick();
      set_instr(CTRL_ADD, 5'd6, 5'd6, 5'd14, 32'h0);
      tick();
      tick();
      set_instr(CTRL_LW, 5'd6, 5'd6, 5'd0, 32'h8);
      tick();
      #1;
      checks++;
      if (stall_o !== 1'b1 || bubble_cnt === 4'd0) begin
         errors++; $display("FAIL midrst_setup got stall %b cnt %0d exp 1 nonzero", stall_o, bubble_cnt);
      end
      rst_n = 0;
      model_clear();
      #1;
      checks++;
      if (dut_word !== exp_word() || stall_o !== 1'b0) begin
         errors++; $display("FAIL midrst_clear got %h stall %b exp 0", dut_word, stall_o);
      end
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_saturation();
      set_instr(CTRL_LW, 5'd9, 5'd9, 5'd0, 32'h0);
      tick();
      for (int i = 0; i < 40; i++) begin
         tick();
         checks++;
         if (dut_word !== exp_word()) begin
            errors++; $display("FAIL sat_step %0d got %h exp %h", i, dut_word, exp_word());
         end
      end
      checks++;
      if (bubble_cnt !== 4'hF) begin
         errors++; $display("FAIL sat_final got %h exp f", bubble_cnt);
      end
   endtask

   task automatic test_random();
      logic [31:0] r, s;
      rst_n = 0; #1; model_clear(); @(negedge clk); rst_n = 1;
      for (int i = 0; i < 600; i++) begin
         r = $urandom; s = $urandom;
         id_valid = (r[1:0] != 2'b00);
         hold_i   = (r[4:2] == 3'b000);
         flush_i  = (r[7:5] == 3'b000);
         id_ctrl  = s[14:0];
         id_ctrl[7] = r[8] | r[9];
         id_rs = {3'b000, r[11:10]}; id_rt = {3'b000, r[13:12]}; id_rd = r[18:14];
         id_shamt = r[23:19]; id_funct = r[29:24];
         id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
         #1;
         checks++;
         if (stall_o !== exp_stall()) begin
            errors++; $display("FAIL rnd_stall %0d got %b exp %b", i, stall_o, exp_stall());
         end
         tick();
         checks++;
         if (dut_word !== exp_word()) begin
            errors++; $display("FAIL rnd_state %0d got %h exp %h", i, dut_word, exp_word());
         end
      end
      hold_i = 0; flush_i = 0;
   endtask

   initial begin
      test_reset();
      test_addi();
      test_load_use();
      test_rt_zero();
      test_flush_priority();
      test_hold();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register directly downstream of the main controller (controller_r0).
- Latches the decoded control word plus ID-stage operands into the EX stage.
- Contains the load-use hazard detector that stalls PC and IF/ID and inserts an EX bubble.
- Applies branch/jump flush and a global memory-hold freeze; keeps a saturating bubble counter for performance debug.

Parameters:
DATA_W, 32, operand/PC width
REG_AW, 5, register-address width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
hold_i  in  1  global freeze (memory wait); highest priority
flush_i  in  1  kill the instruction entering EX (taken branch/jump)
id_valid  in  1  ID holds a real instruction
id_RegDst  in  2  from controller
id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Jump, id_BranchBEQ, id_BranchBNE  in  1 each  from controller
id_RegWriteSrc  in  2  from controller
id_ALUOp  in  3  from controller
id_pc4, id_rs_data, id_rt_data, id_imm  in  DATA_W each  ID operands
id_rs, id_rt, id_rd, id_shamt  in  REG_AW each  register fields
id_funct  in  6  function field
ex_*  out  same widths  registered copies of every id_* input above (ex_valid, ex_RegDst, …, ex_funct)
stall_o  out  1  load-use stall; PC and IF/ID hold when high
bubble_cnt  out  CNT_W  number of load-use bubbles inserted

Behaviour:
- Reset (rst_n low, asynchronous): every ex_* output = 0, ex_valid = 0, bubble_cnt = 0. Stays cleared while rst_n is low. Reset mid-stall drops the bubble; stall_o goes to 0 because ex_valid = 0.
- Control group: ex_RegDst, ALUSrc, MemtoReg, RegWrite, RegWriteSrc, MemRead, MemWrite, Jump, BranchBEQ, BranchBNE, ALUOp.
- Data group: pc4, rs_data, rt_data, imm, rs, rt, rd, shamt, funct.
- load_use (combinational) = id_valid & ex_valid & ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - Conservative: compares both id_rs and id_rt regardless of instruction format.
- stall_o = load_use & ~flush_i. Purely combinational; no latency. Asserted independently of hold_i.
- Register update on each rising clk, in priority order:
  1. hold_i = 1: all registers, including bubble_cnt, keep their values. Upstream keeps flush_i asserted until hold_i drops.
  2. flush_i = 1: ex_valid <= 0; control group <= 0; data group unchanged; bubble_cnt unchanged.
  3. load_use = 1: bubble. ex_valid <= 0; control group <= 0; data group unchanged; bubble_cnt <= bubble_cnt + 1, saturating at all-ones.
  4. Otherwise: ex_valid <= id_valid. If id_valid = 1, all groups load from id_*. If id_valid = 0, control group <= 0 and data group loads.
- Load-use latency:
  - Exactly one bubble per lw-dependent pair.
  - The cycle after the bubble, ex_valid = 0, so load_use = 0 and stall_o = 0; the dependent instruction then enters EX.
- Invariant: ex_valid = 0 implies ex_RegWrite = ex_MemWrite = ex_MemRead = ex_Jump = ex_BranchBEQ = ex_BranchBNE = 0.
- Register $0: an ex_rt of 0 never triggers a stall.
- Throughput: one instruction per cycle when no hazard, flush or hold is present.

Test Plan:
- Reset, then hold rst_n low mid-stream with ex holding lw → all ex_* = 0, stall_o = 0, bubble_cnt = 0 immediately, without waiting for a clock edge.
- addi (ctrl ALUSrc=1, RegWrite=1, ALUOp per controller), id_imm=0x0000_0005, id_valid=1 → the next edge shows the identical control word, ex_imm = 5, ex_valid = 1.
- lw with rt=8 in EX; ID holds add with rs=8 → stall_o = 1; the next edge gives ex_valid = 0, ex_MemRead = 0, bubble_cnt = 1, stall_o = 0; the following edge loads the add.
- lw with rt=0 in EX; ID holds rs=0 → stall_o = 0 and no bubble.
- Load-use condition with flush_i = 1 in the same cycle → stall_o = 0; after the edge ex_valid = 0 and bubble_cnt unchanged.
- hold_i = 1 for 3 cycles with flush_i and load_use present → all ex_* and bubble_cnt frozen. When hold drops, flush is applied on the first edge.
- Force 2^CNT_W + 2 bubbles (or use CNT_W=4 with 18 bubbles) → bubble_cnt saturates at 0xF.
